// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int MAX_DATA_BITS = 9;

  // Callers zero-extend narrower words; extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_ODD:  parity_bit = ~p;
      PAR_EVEN: parity_bit = p;
      default:  parity_bit = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words ahead of the UART shifter; push/pop are
// ignored when full/empty respectively. DEPTH must be a power of two.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       fpga_clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; count alone says which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge fpga_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values independent of statement or block ordering.
  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: baud divider, frame FSM and shifter with a
// valid/ready input. Define UART_TX_FIFO_EN for a FIFO_DEPTH-word input FIFO;
// otherwise a single holding register double-buffers the shifter.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            fpga_clk,
  input  logic                            nrst,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  input  logic [DATA_BITS-1:0]            din,
  output logic                            sout,
  output logic                            busy_tx,
  output logic                            baud_tick,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
      PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_param: illegal parameter combination");
  end

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge fpga_clk) begin
    if (!nrst)                   div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + DIV_ONE;
  end

  assign baud_tick = (div_cnt == DIV_LAST);

  logic                 pending;
  logic [DATA_BITS-1:0] pend_data;
  logic                 pop;
  logic                 accept;

  assign accept = tx_valid && tx_ready;

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .fpga_clk (fpga_clk),
    .nrst     (nrst),
    .push     (accept),
    .wdata    (din),
    .pop      (pop),
    .rdata    (pend_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign tx_ready = !fifo_full;
  assign pending  = !fifo_empty;
`else
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  // Accept needs hold_valid=0 and pop needs hold_valid=1, so they never coincide.
  always_ff @(posedge fpga_clk) begin
    if (!nrst)       hold_valid <= 1'b0;
    else if (accept) hold_valid <= 1'b1;
    else if (pop)    hold_valid <= 1'b0;
  end

  always_ff @(posedge fpga_clk) begin
    if (accept) hold_data <= din;
  end

  assign tx_ready   = !hold_valid;
  assign pending    = hold_valid;
  assign pend_data  = hold_data;
  assign fifo_count = {{(CNT_W-1){1'b0}}, hold_valid};
`endif

  uart_tx_state_e       state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic                 par_q, par_n;
  logic                 sout_q, sout_n;
  logic                 load;

  // A word loads from IDLE or straight off the final stop bit, never mid-frame.
  assign load = baud_tick && pending &&
                ((state == IDLE) || (state == STOP && stop_idx == STOP_LAST));
  assign pop  = load;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    par_n      = par_q;
    sout_n     = sout_q;
    if (baud_tick) begin
      unique case (state)
        IDLE: ;
        START: begin
          state_n   = DATA;
          sout_n    = shift[0];
          shift_n   = shift >> 1;
          bit_idx_n = '0;
        end
        DATA: begin
          if (bit_idx == IDX_LAST) begin
            bit_idx_n = '0;
            if (PARITY_MODE != PAR_NONE) begin
              state_n = PARITY;
              sout_n  = par_q;
            end else begin
              state_n    = STOP;
              sout_n     = 1'b1;
              stop_idx_n = 1'b0;
            end
          end else begin
            sout_n    = shift[0];
            shift_n   = shift >> 1;
            bit_idx_n = bit_idx + IDX_ONE;
          end
        end
        PARITY: begin
          state_n    = STOP;
          sout_n     = 1'b1;
          stop_idx_n = 1'b0;
        end
        STOP: begin
          if (stop_idx == STOP_LAST) state_n = IDLE;
          else                       stop_idx_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
      if (load) begin
        state_n = START;
        sout_n  = 1'b0;
        shift_n = pend_data;
        par_n   = parity_bit(MAX_DATA_BITS'(pend_data), PARITY_MODE);
      end
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      state    <= IDLE;
      sout_q   <= 1'b1;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state    <= state_n;
      sout_q   <= sout_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      par_q    <= par_n;
    end
  end

  always_ff @(posedge fpga_clk) begin
    shift <= shift_n;
  end

  assign sout    = sout_q;
  assign busy_tx = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover 8N1, even/odd parity,
// two stop bits and the buffered-input path (FIFO or holding register).
module tb_uart_tx_param;

  logic       fpga_clk;
  logic       nrst;
  logic       valid_a [4];
  logic       ready_a [4];
  logic [7:0] din_a   [4];
  logic       sout_a  [4];
  logic       busy_a  [4];
  logic       tick_a  [4];
  logic [2:0] fc_a    [4];

  int div_of [4];
  int n_cmp;
  int n_bad;

  typedef struct {
    int          unit;
    logic [7:0]  data;
    logic [11:0] seq;    // transmitted bits, first bit in seq[11]
    int          nbits;
  } frame_vec_t;

  frame_vec_t vecs [7];

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .fpga_clk(fpga_clk), .nrst(nrst), .tx_valid(valid_a[0]), .tx_ready(ready_a[0]),
    .din(din_a[0]), .sout(sout_a[0]), .busy_tx(busy_a[0]), .baud_tick(tick_a[0]),
    .fifo_count(fc_a[0]));

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u1 (
    .fpga_clk(fpga_clk), .nrst(nrst), .tx_valid(valid_a[1]), .tx_ready(ready_a[1]),
    .din(din_a[1]), .sout(sout_a[1]), .busy_tx(busy_a[1]), .baud_tick(tick_a[1]),
    .fifo_count(fc_a[1]));

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) u2 (
    .fpga_clk(fpga_clk), .nrst(nrst), .tx_valid(valid_a[2]), .tx_ready(ready_a[2]),
    .din(din_a[2]), .sout(sout_a[2]), .busy_tx(busy_a[2]), .baud_tick(tick_a[2]),
    .fifo_count(fc_a[2]));

  uart_tx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u3 (
    .fpga_clk(fpga_clk), .nrst(nrst), .tx_valid(valid_a[3]), .tx_ready(ready_a[3]),
    .din(din_a[3]), .sout(sout_a[3]), .busy_tx(busy_a[3]), .baud_tick(tick_a[3]),
    .fifo_count(fc_a[3]));

`ifdef UART_TX_FIFO_EN
  localparam logic [5:0] EXP_READY = 6'b001111;
  localparam logic [2:0] EXP_FILL  = 3'd4;
  localparam logic [2:0] EXP_AFTER = 3'd3;
`else
  localparam logic [5:0] EXP_READY = 6'b000001;
  localparam logic [2:0] EXP_FILL  = 3'd1;
  localparam logic [2:0] EXP_AFTER = 3'd0;
`endif

  initial begin
    fpga_clk = 1'b0;
    forever #5 fpga_clk = ~fpga_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Presents a word and returns right after the edge that accepts it.
  task automatic push(input int u, input logic [7:0] data);
    int n;
    n = 0;
    @(negedge fpga_clk);
    valid_a[u] = 1'b1;
    din_a[u]   = data;
    while (!ready_a[u] && n < 16 * div_of[u]) begin
      @(negedge fpga_clk);
      n++;
    end
    check($sformatf("u%0d_push_%0h_ready_timeout", u, data), (n < 16 * div_of[u]), 1'b1);
    @(posedge fpga_clk);
  endtask

  task automatic release_valid(input int u);
    @(negedge fpga_clk);
    valid_a[u] = 1'b0;
  endtask

  task automatic wait_tick(input int u, input string name);
    int n;
    n = 0;
    @(negedge fpga_clk);
    while (!tick_a[u] && n < 2 * div_of[u]) begin
      @(negedge fpga_clk);
      n++;
    end
    check($sformatf("%s_tick_timeout", name), tick_a[u], 1'b1);
  endtask

  // Checks sout every cycle of a frame, busy throughout, and tick on each bit's last cycle.
  task automatic check_frame(input int u, input logic [11:0] seq, input int nbits,
                             input bit wait_start, input bit expect_idle, input string name);
    int  div;
    int  n;
    bit  found;
    bit  skip_edge;
    div       = div_of[u];
    skip_edge = 1'b0;
    if (wait_start) begin
      n     = 0;
      found = 1'b0;
      while (!found && n < 4 * div) begin
        @(negedge fpga_clk);
        if (sout_a[u] == 1'b0) found = 1'b1;
        n++;
      end
      check($sformatf("%s_start_seen", name), found, 1'b1);
      skip_edge = 1'b1;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < div; c++) begin
        if (skip_edge) skip_edge = 1'b0;
        else           @(negedge fpga_clk);
        check($sformatf("%s_b%0d_c%0d_sout", name, b, c), sout_a[u], seq[11-b]);
        check($sformatf("%s_b%0d_c%0d_busy", name, b, c), busy_a[u], 1'b1);
        if (c == div - 1)
          check($sformatf("%s_b%0d_tick", name, b), tick_a[u], 1'b1);
      end
    end
    if (expect_idle) begin
      @(negedge fpga_clk);
      check($sformatf("%s_idle_busy", name), busy_a[u], 1'b0);
      check($sformatf("%s_idle_sout", name), sout_a[u], 1'b1);
    end
  endtask

  initial begin
    int k0;
    int k3;
    int n;
    n_cmp  = 0;
    n_bad  = 0;
    div_of = '{4, 4, 4, 16};
    for (int i = 0; i < 4; i++) begin
      valid_a[i] = 1'b0;
      din_a[i]   = 8'h00;
    end

    vecs[0] = '{unit: 0, data: 8'hA5, seq: 12'b0101_0010_1100, nbits: 10};
    vecs[1] = '{unit: 0, data: 8'h3C, seq: 12'b0001_1110_0100, nbits: 10};
    vecs[2] = '{unit: 1, data: 8'h07, seq: 12'b0111_0000_0110, nbits: 11};
    vecs[3] = '{unit: 1, data: 8'h80, seq: 12'b0000_0000_1110, nbits: 11};
    vecs[4] = '{unit: 2, data: 8'h07, seq: 12'b0111_0000_0011, nbits: 12};
    vecs[5] = '{unit: 2, data: 8'h00, seq: 12'b0000_0000_0111, nbits: 12};
    vecs[6] = '{unit: 3, data: 8'h5A, seq: 12'b0010_1101_0100, nbits: 10};

    // Reset values, then time to the first tick.
    nrst = 1'b0;
    repeat (3) @(negedge fpga_clk);
    nrst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      check($sformatf("u%0d_rst_sout", u), sout_a[u], 1'b1);
      check($sformatf("u%0d_rst_busy", u), busy_a[u], 1'b0);
      check($sformatf("u%0d_rst_ready", u), ready_a[u], 1'b1);
      check($sformatf("u%0d_rst_tick", u), tick_a[u], 1'b0);
      check($sformatf("u%0d_rst_count", u), fc_a[u], 3'd0);
    end
    k0 = -1;
    k3 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge fpga_clk);
      if (tick_a[0] && k0 < 0) k0 = k;
      if (tick_a[3] && k3 < 0) k3 = k;
    end
    check("u0_first_tick_cycle", k0, 3);
    check("u3_first_tick_cycle", k3, 15);

    // Single frames from the vector table.
    for (int i = 0; i < 7; i++) begin
      fork
        begin
          push(vecs[i].unit, vecs[i].data);
          release_valid(vecs[i].unit);
        end
        check_frame(vecs[i].unit, vecs[i].seq, vecs[i].nbits, 1'b1, 1'b1,
                    $sformatf("vec%0d", i));
      join
    end

    // Back-to-back 0x00 then 0xFF with tx_valid held: 20 contiguous bit periods.
    fork
      begin
        push(0, 8'h00);
        push(0, 8'hFF);
        release_valid(0);
      end
      begin
        check_frame(0, 12'b0000_0000_0100, 10, 1'b1, 1'b0, "b2b_first");
        check_frame(0, 12'b0111_1111_1100, 10, 1'b0, 1'b1, "b2b_second");
      end
    join

    // One-cycle reset in the middle of data bit 3 of a 0x00 frame.
    push(0, 8'h00);
    release_valid(0);
    n = 0;
    while (sout_a[0] != 1'b0 && n < 16) begin
      @(negedge fpga_clk);
      n++;
    end
    check("rst_mid_start_seen", sout_a[0], 1'b0);
    repeat (17) @(negedge fpga_clk);
    check("rst_mid_data3_low", sout_a[0], 1'b0);
    nrst = 1'b0;
    @(negedge fpga_clk);
    nrst = 1'b1;
    check("rst_mid_sout", sout_a[0], 1'b1);
    check("rst_mid_busy", busy_a[0], 1'b0);
    check("rst_mid_count", fc_a[0], 3'd0);
    check("rst_mid_ready", ready_a[0], 1'b1);
    check("rst_mid_tick", tick_a[0], 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge fpga_clk);
      check($sformatf("rst_mid_quiet_c%0d", c), sout_a[0], 1'b1);
    end
    fork
      begin
        push(0, 8'h3C);
        release_valid(0);
      end
      check_frame(0, 12'b0001_1110_0100, 10, 1'b1, 1'b1, "post_rst");
    join

    // Six words on consecutive cycles right after a tick.
    wait_tick(3, "burst_align");
    for (int w = 0; w < 6; w++) begin
      @(negedge fpga_clk);
      check($sformatf("burst_w%0d_ready", w), ready_a[3], EXP_READY[w]);
      valid_a[3] = 1'b1;
      din_a[3]   = 8'h30 + 8'(w);
    end
    @(negedge fpga_clk);
    valid_a[3] = 1'b0;
    check("burst_fill_count", fc_a[3], EXP_FILL);
    check("burst_fill_ready", ready_a[3], 1'b0);
    wait_tick(3, "burst_pop");
    check("burst_pre_pop_count", fc_a[3], EXP_FILL);
    @(negedge fpga_clk);
    check("burst_post_pop_count", fc_a[3], EXP_AFTER);
    check("burst_post_pop_ready", ready_a[3], 1'b1);
    check("burst_post_pop_sout", sout_a[3], 1'b0);
`ifndef UART_TX_FIFO_EN
    valid_a[3] = 1'b1;
    din_a[3]   = 8'h99;
    @(negedge fpga_clk);
    valid_a[3] = 1'b0;
    check("hold_second_count", fc_a[3], 3'd1);
    check("hold_second_ready", ready_a[3], 1'b0);
    check("hold_second_sout", sout_a[3], 1'b0);
`endif
    n = 0;
    while (busy_a[3] && n < 4000) begin
      @(negedge fpga_clk);
      n++;
    end
    check("burst_drain_busy", busy_a[3], 1'b0);
    check("burst_drain_count", fc_a[3], 3'd0);
    check("burst_drain_sout", sout_a[3], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
